// File: rtl/intc_pkg.sv
// Shared types and register map for the interrupt controller.
package intc_pkg;

    typedef logic [7:0] intc_vec_t;

    // Register select encodings on the 3-bit addr bus.
    typedef enum logic [2:0] {
        INTC_PEND   = 3'h0,
        INTC_MASK   = 3'h1,
        INTC_EDGE   = 3'h2,
        INTC_POL    = 3'h3,
        INTC_ID     = 3'h4,
        INTC_RAW    = 3'h5,
        INTC_SWTRIG = 3'h6,
        INTC_CTRL   = 3'h7
    } intc_reg_e;

    // CTRL register bit holding the global interrupt enable.
    localparam int unsigned CTRL_GEN = 0;

    // One bit per implemented source; bits at or above n stay zero.
    function automatic intc_vec_t intc_valid_mask(input int unsigned n);
        intc_vec_t m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m[i[2:0]] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU register bus shared with the other peripherals (cs/rwb/addr/data).
interface interrupt_controller_if;
    logic       cs;
    logic       rwb;
    logic [2:0] addr;
    logic [7:0] i_data;
    logic [7:0] o_data;

    modport master (output cs, output rwb, output addr, output i_data, input o_data);
    modport slave  (input cs, input rwb, input addr, input i_data, output o_data);
endinterface

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
module intc_prio_enc
    import intc_pkg::*;
(
    input  intc_vec_t  req,
    output logic       any,
    output logic [2:0] id
);

    // Scan upward and keep the first hit.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i[2:0]] && !any) begin
                any = 1'b1;
                id  = i[2:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the 65C02: latches, masks and prioritises
// peripheral irq lines and drives the active-low irqb input.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter logic [7:0]  POL_RESET = 8'hFF
)
(
    input  logic                 clk,
    input  logic                 reset,
    interrupt_controller_if.slave bus,
    input  logic [N_SRC-1:0]     irq_src,
    output logic                 irqb
);

    localparam intc_vec_t VALID = intc_valid_mask(N_SRC);

    intc_vec_t  pend, mask, edge_sel, pol, prev;
    logic       ctrl_gen;

    intc_vec_t  src_w, act, rise, clr, swset, pend_next;
    intc_vec_t  req;
    logic       any;
    logic [2:0] id;
    logic       wr;
    intc_reg_e  reg_sel;

    assign wr      = bus.cs & ~bus.rwb;
    assign reg_sel = intc_reg_e'(bus.addr);
    assign req     = pend & mask;

    intc_prio_enc u_prio (
        .req (req),
        .any (any),
        .id  (id)
    );

    // Polarity-adjusted inputs, edge detection and next pending vector.
    // Sets are OR-ed in after clears so a same-cycle set beats a clear.
    always_comb begin
        src_w = '0;
        src_w[N_SRC-1:0] = irq_src;
        act   = (src_w ^ pol) & VALID;
        rise  = act & ~prev;
        clr   = '0;
        swset = '0;
        if (wr) begin
            case (reg_sel)
                INTC_PEND:   clr   = bus.i_data;
                INTC_ID:     clr   = intc_vec_t'(1) << bus.i_data[2:0];
                INTC_SWTRIG: swset = bus.i_data;
                default:     ;
            endcase
        end
        pend_next = ((edge_sel & ((pend & ~clr) | rise | swset)) |
                     (~edge_sel & (act | swset))) & VALID;
    end

    // Register state and irqb, updated on the falling edge like the rest of the bus.
    always_ff @(negedge clk) begin
        if (reset) begin
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            pol      <= POL_RESET & VALID;
            ctrl_gen <= 1'b0;
            irqb     <= 1'b1;
            prev     <= (src_w ^ POL_RESET) & VALID;
        end else begin
            pend <= pend_next;
            prev <= act;
            irqb <= ~(ctrl_gen & any);
            if (wr) begin
                case (reg_sel)
                    INTC_MASK: mask     <= bus.i_data & VALID;
                    INTC_EDGE: edge_sel <= bus.i_data & VALID;
                    INTC_POL:  pol      <= bus.i_data & VALID;
                    INTC_CTRL: ctrl_gen <= bus.i_data[CTRL_GEN];
                    default:   ;
                endcase
            end
        end
    end

    // Combinational read mux, not gated by cs.
    always_comb begin
        bus.o_data = '0;
        case (reg_sel)
            INTC_PEND:   bus.o_data = pend;
            INTC_MASK:   bus.o_data = mask;
            INTC_EDGE:   bus.o_data = edge_sel;
            INTC_POL:    bus.o_data = pol;
            INTC_ID:     bus.o_data = {any, 4'b0000, id};
            INTC_RAW:    bus.o_data = act;
            INTC_SWTRIG: bus.o_data = '0;
            INTC_CTRL:   bus.o_data = {7'b0000000, ctrl_gen};
            default:     bus.o_data = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed table-driven bench for interrupt_controller.
module tb_interrupt_controller;
    import intc_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] irq_src;
    logic       irqb;

    interrupt_controller_if bus ();

    interrupt_controller #(.N_SRC(8), .POL_RESET(8'hFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .irq_src (irq_src),
        .irqb    (irqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] src;
        bit         chk_rd;
        logic [7:0] exp_rd;
        logic       exp_irqb;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add_w(input logic [2:0] a, input logic [7:0] d, input logic [7:0] s, input logic ei);
        vec_t v;
        v = '{we: 1'b1, addr: a, data: d, src: s, chk_rd: 1'b0, exp_rd: 8'h00, exp_irqb: ei};
        tbl.push_back(v);
    endtask

    task automatic add_r(input logic [2:0] a, input logic [7:0] s, input logic [7:0] e, input logic ei);
        vec_t v;
        v = '{we: 1'b0, addr: a, data: 8'h00, src: s, chk_rd: 1'b1, exp_rd: e, exp_irqb: ei};
        tbl.push_back(v);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one bus cycle just after the falling edge, sample at the rising edge.
    // The state seen is the one before this cycle's write commits.
    task automatic cyc(input string name, input logic rst_v, input bit we, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] s, input bit chk_rd,
                       input logic [7:0] exp_rd, input logic exp_irqb);
        @(negedge clk);
        #1;
        reset       = rst_v;
        irq_src     = s;
        bus.cs      = 1'b1;
        bus.rwb     = ~we;
        bus.addr    = a;
        bus.i_data  = d;
        @(posedge clk);
        if (chk_rd) chk8({name, ".rd"}, bus.o_data, exp_rd);
        chk8({name, ".irqb"}, {7'b0, irqb}, {7'b0, exp_irqb});
    endtask

    initial begin
        reset      = 1'b1;
        irq_src    = 8'hFF;
        bus.cs     = 1'b0;
        bus.rwb    = 1'b1;
        bus.addr   = '0;
        bus.i_data = '0;

        // Reset values with active-low lines idle high.
        add_r(3'd0, 8'hFF, 8'h00, 1'b1);
        add_r(3'd1, 8'hFF, 8'h00, 1'b1);
        add_r(3'd2, 8'hFF, 8'h00, 1'b1);
        add_r(3'd3, 8'hFF, 8'hFF, 1'b1);
        add_r(3'd4, 8'hFF, 8'h00, 1'b1);
        add_r(3'd5, 8'hFF, 8'h00, 1'b1);
        add_r(3'd6, 8'hFF, 8'h00, 1'b1);
        add_r(3'd7, 8'hFF, 8'h00, 1'b1);
        // Edge path on source 0.
        add_w(3'd3, 8'h00, 8'hFF, 1'b1);
        add_w(3'd2, 8'h01, 8'h00, 1'b1);
        add_w(3'd1, 8'h01, 8'h00, 1'b1);
        add_w(3'd7, 8'h01, 8'h00, 1'b1);
        add_r(3'd0, 8'h01, 8'h00, 1'b1);
        add_r(3'd0, 8'h00, 8'h01, 1'b1);
        add_r(3'd4, 8'h00, 8'h80, 1'b0);
        add_w(3'd4, 8'h00, 8'h00, 1'b0);
        add_r(3'd0, 8'h00, 8'h00, 1'b0);
        add_r(3'd0, 8'h00, 8'h00, 1'b1);
        // Level source 2 with mask; W1C ignored.
        add_w(3'd2, 8'h00, 8'h00, 1'b1);
        add_w(3'd1, 8'h04, 8'h00, 1'b1);
        add_r(3'd0, 8'h04, 8'h00, 1'b1);
        add_w(3'd0, 8'h04, 8'h04, 1'b1);
        add_r(3'd0, 8'h04, 8'h04, 1'b0);
        add_r(3'd4, 8'h04, 8'h82, 1'b0);
        add_r(3'd0, 8'h00, 8'h04, 1'b0);
        add_r(3'd0, 8'h00, 8'h00, 1'b0);
        add_r(3'd0, 8'h00, 8'h00, 1'b1);
        // Priority between edge sources 3 and 5.
        add_w(3'd2, 8'hFF, 8'h00, 1'b1);
        add_w(3'd1, 8'hFF, 8'h00, 1'b1);
        add_r(3'd0, 8'h28, 8'h00, 1'b1);
        add_r(3'd4, 8'h00, 8'h83, 1'b1);
        add_w(3'd4, 8'h03, 8'h00, 1'b0);
        add_r(3'd4, 8'h00, 8'h85, 1'b0);
        add_w(3'd4, 8'h05, 8'h00, 1'b0);
        add_r(3'd4, 8'h00, 8'h00, 1'b0);
        add_r(3'd4, 8'h00, 8'h00, 1'b1);
        // Edge and W1C on source 1 in the same cycle; CTRL off keeps irqb high.
        add_w(3'd7, 8'h00, 8'h00, 1'b1);
        add_w(3'd0, 8'h02, 8'h02, 1'b1);
        add_r(3'd0, 8'h02, 8'h02, 1'b1);
        add_r(3'd0, 8'h00, 8'h02, 1'b1);
        add_r(3'd4, 8'h00, 8'h81, 1'b1);
        add_w(3'd0, 8'h02, 8'h00, 1'b1);
        add_r(3'd0, 8'h00, 8'h00, 1'b1);
        // SWTRIG on edge source 6.
        add_w(3'd1, 8'h40, 8'h00, 1'b1);
        add_w(3'd7, 8'h01, 8'h00, 1'b1);
        add_w(3'd6, 8'h40, 8'h00, 1'b1);
        add_r(3'd0, 8'h00, 8'h40, 1'b1);
        add_r(3'd6, 8'h00, 8'h00, 1'b0);
        add_r(3'd4, 8'h00, 8'h86, 1'b0);
        add_w(3'd0, 8'h40, 8'h00, 1'b0);
        add_r(3'd0, 8'h00, 8'h00, 1'b0);
        // Active-low source 7: idle high, then drive low.
        add_w(3'd3, 8'h80, 8'h00, 1'b1);
        add_r(3'd5, 8'h80, 8'h00, 1'b1);
        add_r(3'd0, 8'h80, 8'h00, 1'b1);
        add_r(3'd5, 8'h00, 8'h80, 1'b1);
        add_r(3'd0, 8'h00, 8'h80, 1'b1);
        add_r(3'd4, 8'h00, 8'h00, 1'b1);

        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        foreach (tbl[k]) begin
            cyc($sformatf("row%0d", k), 1'b0, tbl[k].we, tbl[k].addr, tbl[k].data, tbl[k].src,
                tbl[k].chk_rd, tbl[k].exp_rd, tbl[k].exp_irqb);
        end

        // Unmask pending source 7, then reset mid-operation drops it.
        cyc("rst_mask",  1'b0, 1'b1, 3'd1, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1);
        cyc("rst_pend",  1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h80, 1'b1);
        cyc("rst_id",    1'b0, 1'b0, 3'd4, 8'h00, 8'h00, 1'b1, 8'h87, 1'b0);
        cyc("rst_on",    1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h80, 1'b0);
        cyc("rst_pend0", 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        cyc("rst_pol",   1'b0, 1'b0, 3'd3, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1);
        cyc("rst_msk0",  1'b0, 1'b0, 3'd1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        cyc("rst_id0",   1'b0, 1'b0, 3'd4, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        // SWTRIG on a level source lasts a single cycle.
        cyc("lvl_sw",    1'b0, 1'b1, 3'd6, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1);
        cyc("lvl_sw1",   1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h01, 1'b1);
        cyc("lvl_sw0",   1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);

        @(negedge clk);
        #1 bus.cs = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
